wgt_load_ctrl: RTL and testbench

Upstream feeder for the per-lane weight buffer array. It accepts a 128-bit weight beat stream and scatters each beat to one of SIZE weight-buffer lanes. For every write it produces a one-hot lane write enable, a 5-bit per-lane address and a registered data slot. When the full kernel set has been written it raises i2c_ready, which releases the downstream buffers for cube fetch.

---
 rtl/wgt_pkg.sv | 33 +++
 rtl/wgt_lane_demux.sv | 60 ++++++
 rtl/wgt_load_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_wgt_load_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wgt_pkg.sv
// -----------------------------------------------------------------------------
// wgt_pkg
// Shared constants, FSM state type and configuration check for the weight
// load controller and its lane demultiplexer.
//   SIZE      : number of weight-buffer lanes
//   ADDR_WID  : per-lane write address width
//   BEAT_WID  : width of one incoming weight beat
//   KSIZE_MAX : largest legal kernel side
// -----------------------------------------------------------------------------
package wgt_pkg;

    localparam int SIZE      = 8;
    localparam int ADDR_WID  = 5;
    localparam int BEAT_WID  = 128;
    localparam int KSIZE_MAX = 5;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_EMPTY = 2'd1,
        LOAD       = 2'd2,
        DONE       = 2'd3
    } state_t;

    // A load is legal when the kernel side is 1..KSIZE_MAX and the
    // active lane count is 1..lanes.
    function automatic logic cfg_legal(input logic [2:0] k,
                                       input logic [3:0] vn,
                                       input logic [3:0] lanes);
        return (k != 3'd0) && (k <= 3'(KSIZE_MAX)) &&
               (vn != 4'd0) && (vn <= lanes);
    endfunction

endpackage

// File: rtl/wgt_lane_demux.sv
// -----------------------------------------------------------------------------
// wgt_lane_demux
// Registers one accepted weight beat into the slot of the selected lane.
// One cycle after 'valid', wr_en carries a one-hot strobe for 'lane', and the
// lane's address field and data slot hold the new values. Unselected lanes
// keep their previous address and data.
// Ports:
//   clock, rst_n : clock, asynchronous active-low reset
//   valid        : a beat is being written this cycle
//   lane         : destination lane index
//   addr         : per-lane write address
//   data         : beat payload
//   wr_en        : registered one-hot lane strobe
//   wr_addr      : packed per-lane address fields (lane i at [i*AW +: AW])
//   data_out     : packed per-lane data slots (lane i at [i*BW +: BW])
// -----------------------------------------------------------------------------
module wgt_lane_demux
    import wgt_pkg::*;
#(
    parameter  int LANES = SIZE,
    parameter  int AW    = ADDR_WID,
    parameter  int BW    = BEAT_WID,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic [LW-1:0]         lane,
    input  logic [AW-1:0]         addr,
    input  logic [BW-1:0]         data,
    output logic [LANES-1:0]      wr_en,
    output logic [AW*LANES-1:0]   wr_addr,
    output logic [BW*LANES-1:0]   data_out
);

    logic [LANES-1:0]    wr_en_r;
    logic [AW*LANES-1:0] wr_addr_r;
    logic [BW*LANES-1:0] data_r;

    // Strobe lasts one cycle; address and data slots are sticky per lane.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r   <= '0;
            wr_addr_r <= '0;
            data_r    <= '0;
        end else begin
            wr_en_r <= '0;
            if (valid) begin
                wr_en_r[lane]            <= 1'b1;
                wr_addr_r[lane*AW +: AW] <= addr;
                data_r[lane*BW +: BW]    <= data;
            end
        end
    end

    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign data_out = data_r;

endmodule

// File: rtl/wgt_load_ctrl.sv
// -----------------------------------------------------------------------------
// wgt_load_ctrl
// Feeds the per-lane weight buffers. After a legal start and once the buffers
// report empty, it accepts ksize*ksize*valid_num beats and scatters them
// address-outer / lane-inner: beat n goes to lane n mod valid_num at address
// n div valid_num. i2c_ready rises once the whole kernel set is written.
// Ports:
//   clock, rst_n          : clock, asynchronous active-low reset
//   start                 : one-cycle load request
//   cfg_ksize             : kernel side (1..5)
//   cfg_valid_num         : active lanes (1..SIZE)
//   buf_empty_wgt         : downstream buffers empty
//   s_data/s_valid/s_ready: beat stream handshake
//   wgt_wr_en             : one-hot lane write strobe
//   wgt_wr_addr           : per-lane write addresses
//   weights_out           : per-lane data slots
//   ksize, valid_num      : latched configuration
//   i2c_ready             : load complete (level)
//   busy                  : waiting for empty buffers or loading
//   err_cfg               : one-cycle pulse on an illegal start
// -----------------------------------------------------------------------------
module wgt_load_ctrl #(
    parameter  int DATA_WID = 16,
    parameter  int SIZE     = wgt_pkg::SIZE,
    parameter  int ADDR_WID = wgt_pkg::ADDR_WID,
    localparam int BEAT_W   = (wgt_pkg::BEAT_WID / DATA_WID) * DATA_WID
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [2:0]                 cfg_ksize,
    input  logic [3:0]                 cfg_valid_num,
    input  logic                       buf_empty_wgt,
    input  logic [BEAT_W-1:0]          s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [SIZE-1:0]            wgt_wr_en,
    output logic [ADDR_WID*SIZE-1:0]   wgt_wr_addr,
    output logic [BEAT_W*SIZE-1:0]     weights_out,
    output logic [2:0]                 ksize,
    output logic [3:0]                 valid_num,
    output logic                       i2c_ready,
    output logic                       busy,
    output logic                       err_cfg
);

    import wgt_pkg::state_t;
    import wgt_pkg::IDLE;
    import wgt_pkg::WAIT_EMPTY;
    import wgt_pkg::LOAD;
    import wgt_pkg::DONE;
    import wgt_pkg::cfg_legal;

    localparam int LANE_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    state_t               state_r;
    state_t               state_s;

    logic [LANE_W-1:0]    lane_cnt_r;
    logic [ADDR_WID-1:0]  addr_cnt_r;
    logic [7:0]           beat_cnt_r;
    logic [7:0]           total_r;
    logic [2:0]           ksize_r;
    logic [3:0]           valid_num_r;
    logic                 s_ready_r;
    logic                 busy_r;
    logic                 err_cfg_r;
    logic                 i2c_ready_r;

    logic                 can_start_s;
    logic                 start_ok_s;
    logic                 start_bad_s;
    logic                 accept_s;
    logic                 last_s;
    logic                 lane_wrap_s;

    // Handshake decode and next-state selection.
    always_comb begin
        can_start_s = 1'b0;
        start_ok_s  = 1'b0;
        start_bad_s = 1'b0;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        lane_wrap_s = 1'b0;
        state_s     = state_r;

        can_start_s = (state_r == IDLE) || (state_r == DONE);
        if (start && can_start_s) begin
            start_ok_s  = cfg_legal(cfg_ksize, cfg_valid_num, 4'(SIZE));
            start_bad_s = !cfg_legal(cfg_ksize, cfg_valid_num, 4'(SIZE));
        end else begin
            start_ok_s  = 1'b0;
            start_bad_s = 1'b0;
        end

        // s_ready_r is high exactly while in LOAD.
        accept_s    = s_valid && s_ready_r;
        last_s      = accept_s && (beat_cnt_r == (total_r - 8'd1));
        lane_wrap_s = (4'(lane_cnt_r) == (valid_num_r - 4'd1));

        case (state_r)
            IDLE, DONE: begin
                if (start_ok_s) begin
                    state_s = WAIT_EMPTY;
                end else begin
                    state_s = state_r;
                end
            end
            WAIT_EMPTY: begin
                if (buf_empty_wgt) begin
                    state_s = LOAD;
                end else begin
                    state_s = WAIT_EMPTY;
                end
            end
            LOAD: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = LOAD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Status outputs, registered from the next state so they track it
    // without a cycle of lag; s_ready drops on the final accept edge.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s_ready_r   <= 1'b0;
            busy_r      <= 1'b0;
            err_cfg_r   <= 1'b0;
            i2c_ready_r <= 1'b0;
        end else begin
            s_ready_r <= (state_s == LOAD);
            busy_r    <= (state_s == WAIT_EMPTY) || (state_s == LOAD);
            err_cfg_r <= start_bad_s;
            // DONE is entered on the last accept; the final strobe appears in
            // that same cycle, so i2c_ready follows one cycle behind it.
            if (start_ok_s) begin
                i2c_ready_r <= 1'b0;
            end else if (state_r == DONE) begin
                i2c_ready_r <= 1'b1;
            end else begin
                i2c_ready_r <= i2c_ready_r;
            end
        end
    end

    // Configuration latch and beat/lane/address counters.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ksize_r     <= 3'd0;
            valid_num_r <= 4'd0;
            total_r     <= 8'd0;
            beat_cnt_r  <= 8'd0;
            lane_cnt_r  <= '0;
            addr_cnt_r  <= '0;
        end else if (start_ok_s) begin
            ksize_r     <= cfg_ksize;
            valid_num_r <= cfg_valid_num;
            total_r     <= 8'(cfg_ksize) * 8'(cfg_ksize) * 8'(cfg_valid_num);
            beat_cnt_r  <= 8'd0;
            lane_cnt_r  <= '0;
            addr_cnt_r  <= '0;
        end else if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
            if (lane_wrap_s) begin
                lane_cnt_r <= '0;
                addr_cnt_r <= addr_cnt_r + ADDR_WID'(1);
            end else begin
                lane_cnt_r <= lane_cnt_r + LANE_W'(1);
            end
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    wgt_lane_demux #(
        .LANES (SIZE),
        .AW    (ADDR_WID),
        .BW    (BEAT_W)
    ) u_demux (
        .clock    (clock),
        .rst_n    (rst_n),
        .valid    (accept_s),
        .lane     (lane_cnt_r),
        .addr     (addr_cnt_r),
        .data     (s_data),
        .wr_en    (wgt_wr_en),
        .wr_addr  (wgt_wr_addr),
        .data_out (weights_out)
    );

    assign s_ready   = s_ready_r;
    assign busy      = busy_r;
    assign err_cfg   = err_cfg_r;
    assign i2c_ready = i2c_ready_r;
    assign ksize     = ksize_r;
    assign valid_num = valid_num_r;

endmodule

// File: tb/tb_wgt_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wgt_load_ctrl
// Self-checking bench for wgt_load_ctrl: a table of load scenarios applied in
// a loop, each compared cycle by cycle against a reference model that
// computes lane = n mod valid_num and addr = n div valid_num per beat, plus a
// hand-written asynchronous-reset-mid-load sequence.
// -----------------------------------------------------------------------------
module tb_wgt_load_ctrl;

    localparam int SIZE = 8;
    localparam int AW   = 5;
    localparam int BW   = 128;

    logic                 clock;
    logic                 rst_n;
    logic                 start;
    logic [2:0]           cfg_ksize;
    logic [3:0]           cfg_valid_num;
    logic                 buf_empty_wgt;
    logic [BW-1:0]        s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [SIZE-1:0]      wgt_wr_en;
    logic [AW*SIZE-1:0]   wgt_wr_addr;
    logic [BW*SIZE-1:0]   weights_out;
    logic [2:0]           ksize;
    logic [3:0]           valid_num;
    logic                 i2c_ready;
    logic                 busy;
    logic                 err_cfg;

    wgt_load_ctrl dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_ksize     (cfg_ksize),
        .cfg_valid_num (cfg_valid_num),
        .buf_empty_wgt (buf_empty_wgt),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .wgt_wr_en     (wgt_wr_en),
        .wgt_wr_addr   (wgt_wr_addr),
        .weights_out   (weights_out),
        .ksize         (ksize),
        .valid_num     (valid_num),
        .i2c_ready     (i2c_ready),
        .busy          (busy),
        .err_cfg       (err_cfg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 waiting for empty buffers, 2 loading, 3 complete
    int              m_phase, m_n, m_total, m_ks, m_vn;
    logic [SIZE-1:0] m_wr_en;
    logic [AW*SIZE-1:0] m_addr;
    logic [BW*SIZE-1:0] m_data;
    logic            m_i2c, m_pend, m_err;

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_total = 0; m_ks = 0; m_vn = 0;
        m_wr_en = '0; m_addr = '0; m_data = '0;
        m_i2c = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        int old_phase;
        int lane;
        old_phase = m_phase;
        m_wr_en   = '0;
        m_err     = 1'b0;
        if (m_pend) begin
            m_i2c  = 1'b1;
            m_pend = 1'b0;
        end
        if (old_phase == 2) begin
            if (s_valid) begin
                lane = m_n % m_vn;
                m_wr_en[lane] = 1'b1;
                m_addr[lane*AW +: AW] = AW'(m_n / m_vn);
                m_data[lane*BW +: BW] = s_data;
                m_n++;
                if (m_n == m_total) begin
                    m_phase = 3;
                    m_pend  = 1'b1;
                end
            end
        end else if (old_phase == 1) begin
            if (buf_empty_wgt) m_phase = 2;
        end else if (start) begin
            if (cfg_ksize >= 3'd1 && cfg_ksize <= 3'd5 &&
                cfg_valid_num >= 4'd1 && cfg_valid_num <= 4'(SIZE)) begin
                m_ks = int'(cfg_ksize);
                m_vn = int'(cfg_valid_num);
                m_total = m_ks * m_ks * m_vn;
                m_n = 0;
                m_i2c = 1'b0;
                m_pend = 1'b0;
                m_phase = 1;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        chk("s_ready", s_ready, (m_phase == 2));
        chk("busy", busy, (m_phase == 1 || m_phase == 2));
        chk("i2c_ready", i2c_ready, m_i2c);
        chk("err_cfg", err_cfg, m_err);
        chk("wr_en", wgt_wr_en, m_wr_en);
        chk("ksize", ksize, m_ks);
        chk("valid_num", valid_num, m_vn);
        for (int l = 0; l < SIZE; l++) begin
            chk($sformatf("wr_addr[%0d]", l), wgt_wr_addr[l*AW +: AW], m_addr[l*AW +: AW]);
            chk($sformatf("weights[%0d]", l), weights_out[l*BW +: BW], m_data[l*BW +: BW]);
        end
    endtask

    // ---------------- observations of the DUT during one load ----------------
    int              obs_writes, obs_first_cyc, obs_last_cyc, obs_i2c_rise, obs_err, obs_ready_wait;
    logic [SIZE-1:0] obs_first_en, obs_last_en, obs_w9_en;
    logic [AW-1:0]   obs_first_addr, obs_last_addr, obs_w9_addr;
    logic [SIZE-1:0] obs_seq [3];
    logic            obs_i2c_prev;

    task automatic observe(input int cyc);
        logic [AW-1:0] a;
        a = '0;
        if (wgt_wr_en != '0) begin
            for (int l = 0; l < SIZE; l++) begin
                if (wgt_wr_en[l]) a = wgt_wr_addr[l*AW +: AW];
            end
            if (obs_writes == 0) begin
                obs_first_cyc  = cyc;
                obs_first_en   = wgt_wr_en;
                obs_first_addr = a;
            end
            if (obs_writes < 3) obs_seq[obs_writes] = wgt_wr_en;
            if (obs_writes == 9) begin
                obs_w9_en   = wgt_wr_en;
                obs_w9_addr = a;
            end
            obs_writes++;
            obs_last_cyc  = cyc;
            obs_last_en   = wgt_wr_en;
            obs_last_addr = a;
        end
        if (i2c_ready && !obs_i2c_prev && obs_i2c_rise < 0) obs_i2c_rise = cyc;
        obs_i2c_prev = i2c_ready;
        if (err_cfg) obs_err++;
        if (s_ready && m_phase == 1) obs_ready_wait++;
    endtask

    // vmode: 0 continuous s_valid, 1 toggling, 2 random (plus random
    // buf_empty drops and ignored starts while busy). dmode: 0 random data,
    // 1 data = 0xA + beat index. abort_at > 0 stops after that many beats.
    task automatic run_load(input int ks, input int vn, input int edly,
                            input int vmode, input int dmode, input int abort_at);
        int  tail;
        int  wcnt;
        bit  finished;
        tail = 0; wcnt = 0; finished = 1'b0;
        obs_writes = 0; obs_first_cyc = -1; obs_last_cyc = -1; obs_i2c_rise = -1;
        obs_err = 0; obs_ready_wait = 0; obs_i2c_prev = 1'b1;
        obs_first_en = '0; obs_last_en = '0; obs_w9_en = '0;
        obs_first_addr = '0; obs_last_addr = '0; obs_w9_addr = '0;
        for (int k = 0; k < 3; k++) obs_seq[k] = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            compare_all();
            observe(cyc);
            if (tail >= 5 || (abort_at > 0 && m_n >= abort_at && m_phase == 2)) begin
                finished = 1'b1;
                break;
            end
            start         = (cyc == 0);
            cfg_ksize     = 3'(ks);
            cfg_valid_num = 4'(vn);
            if (vmode == 2 && cyc > 0 && (m_phase == 1 || m_phase == 2)) begin
                start         = ($urandom_range(0, 15) == 0);
                cfg_ksize     = 3'($urandom_range(0, 7));
                cfg_valid_num = 4'($urandom_range(0, 15));
            end
            if (m_phase == 1) begin
                buf_empty_wgt = (wcnt >= edly);
                wcnt++;
            end else if (m_phase == 2 && vmode == 2) begin
                buf_empty_wgt = ($urandom_range(0, 1) == 1);
            end else begin
                buf_empty_wgt = 1'b1;
            end
            case (vmode)
                0: s_valid = 1'b1;
                1: s_valid = (cyc % 2 == 0);
                default: s_valid = ($urandom_range(0, 3) != 0);
            endcase
            if (dmode == 1) s_data = 128'hA + 128'(m_n);
            else s_data = {$urandom, $urandom, $urandom, $urandom};
            model_step();
            if (cyc > 0 && (m_phase == 0 || m_phase == 3)) tail++;
            @(posedge clock);
        end
        chk("load_timeout", finished, 1'b1);
        start   = 1'b0;
        s_valid = 1'b0;
    endtask

    typedef struct {
        int ks, vn, edly, vmode, dmode;
        int exp_err, exp_writes, exp_last_en, exp_last_addr;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{3, 8,  0, 0, 0, 0,  72, 8'h80,  8};
        tbl[1] = '{1, 3,  0, 0, 1, 0,   3, 8'h04,  0};
        tbl[2] = '{2, 4, 10, 0, 0, 0,  16, 8'h08,  3};
        tbl[3] = '{6, 4,  0, 0, 0, 1,   0, 0,      0};
        tbl[4] = '{2, 0,  0, 0, 0, 1,   0, 0,      0};
        tbl[5] = '{5, 8,  0, 1, 0, 0, 200, 8'h80, 24};
        tbl[6] = '{0, 3,  0, 0, 0, 1,   0, 0,      0};
        tbl[7] = '{4, 5,  3, 2, 0, 0,  80, 8'h10, 15};
        tbl[8] = '{5, 9,  0, 0, 0, 1,   0, 0,      0};
        tbl[9] = '{1, 1,  0, 2, 0, 0,   1, 8'h01,  0};

        rst_n = 1'b0; start = 1'b0; cfg_ksize = 3'd0; cfg_valid_num = 4'd0;
        buf_empty_wgt = 1'b0; s_data = '0; s_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        compare_all();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_load(tbl[i].ks, tbl[i].vn, tbl[i].edly, tbl[i].vmode, tbl[i].dmode, 0);
            chk($sformatf("writes#%0d", i), obs_writes, tbl[i].exp_writes);
            chk($sformatf("err_pulses#%0d", i), obs_err, tbl[i].exp_err);
            if (tbl[i].exp_writes > 0) begin
                chk($sformatf("first_en#%0d", i), obs_first_en, 8'h01);
                chk($sformatf("first_addr#%0d", i), obs_first_addr, 5'd0);
                chk($sformatf("last_en#%0d", i), obs_last_en, tbl[i].exp_last_en);
                chk($sformatf("last_addr#%0d", i), obs_last_addr, tbl[i].exp_last_addr);
                chk($sformatf("i2c_latency#%0d", i), obs_i2c_rise - obs_last_cyc, 1);
            end
            if (i == 0) begin
                chk("burst_span", obs_last_cyc - obs_first_cyc + 1, 72);
                chk("beat9_en", obs_w9_en, 8'h02);
                chk("beat9_addr", obs_w9_addr, 5'd1);
            end
            if (i == 1) begin
                chk("seq0", obs_seq[0], 8'h01);
                chk("seq1", obs_seq[1], 8'h02);
                chk("seq2", obs_seq[2], 8'h04);
            end
            if (i == 2) chk("ready_in_wait", obs_ready_wait, 0);
        end

        // Asynchronous reset after 40 beats of a 200-beat load.
        run_load(5, 8, 0, 0, 0, 40);
        rst_n = 1'b0;
        #1;
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_i2c", i2c_ready, 1'b0);
        chk("rst_err", err_cfg, 1'b0);
        chk("rst_wr_en", wgt_wr_en, '0);
        chk("rst_wr_addr", wgt_wr_addr, '0);
        chk("rst_weights_any", |weights_out, 1'b0);
        chk("rst_ksize", ksize, 3'd0);
        chk("rst_valid_num", valid_num, 4'd0);
        model_reset();
        @(negedge clock);
        rst_n = 1'b1;
        run_load(2, 3, 0, 0, 0, 0);
        chk("restart_first_en", obs_first_en, 8'h01);
        chk("restart_first_addr", obs_first_addr, 5'd0);
        chk("restart_writes", obs_writes, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
